// File: rtl/servant_ram_loader_if.sv
// Byte-stream and Wishbone write-port bundle of the servant RAM loader.
// master = loader side, slave = byte source plus RAM responder side.
interface servant_ram_loader_if;
  logic [7:0]  i_dat;
  logic        i_vld;
  logic        i_last;
  logic        o_rdy;
  logic [29:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        i_wb_ack;

  modport master (
    input  i_dat, i_vld, i_last, i_wb_ack,
    output o_rdy, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
  );

  modport slave (
    output i_dat, i_vld, i_last, i_wb_ack,
    input  o_rdy, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
  );
endinterface

// File: rtl/servant_ram_loader.sv
// Packs a byte stream little-endian into words and writes them to the servant
// RAM over Wishbone from word 0 upward; flags completion and address wrap.
module servant_ram_loader #(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic                  i_wb_clk,
  input  logic                  i_wb_rst_n,
  servant_ram_loader_if.master  bus,
  output logic                  o_done,
  output logic                  o_wrap
);

  typedef enum logic [1:0] {COLLECT, WRITE, DONE} state_t;

  state_t        state, state_d;
  logic [1:0]    lane, lane_d;
  logic [aw-3:0] wadr, wadr_d;
  logic [31:0]   dat, dat_d;
  logic [3:0]    sel, sel_d;
  logic          rdy, rdy_d;
  logic          cyc, cyc_d;
  logic          last, last_d;
  logic          done_d, wrap_d;

  assign bus.o_rdy    = rdy;
  assign bus.o_wb_cyc = cyc;
  assign bus.o_wb_we  = cyc;
  assign bus.o_wb_dat = dat;
  assign bus.o_wb_sel = sel;
  assign bus.o_wb_adr = {{(32-aw){1'b0}}, wadr};

  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      state  <= COLLECT;
      lane   <= '0;
      wadr   <= '0;
      dat    <= '0;
      sel    <= '0;
      rdy    <= 1'b0;
      cyc    <= 1'b0;
      last   <= 1'b0;
      o_done <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      state  <= state_d;
      lane   <= lane_d;
      wadr   <= wadr_d;
      dat    <= dat_d;
      sel    <= sel_d;
      rdy    <= rdy_d;
      cyc    <= cyc_d;
      last   <= last_d;
      o_done <= done_d;
      o_wrap <= wrap_d;
    end
  end

  // Computes the next value of every output register so all outputs stay registered.
  always_comb begin
    state_d = state;
    lane_d  = lane;
    wadr_d  = wadr;
    dat_d   = dat;
    sel_d   = sel;
    rdy_d   = rdy;
    cyc_d   = cyc;
    last_d  = last;
    done_d  = o_done;
    wrap_d  = o_wrap;
    case (state)
      COLLECT: begin
        rdy_d = 1'b1;
        if (bus.i_vld && rdy) begin
          dat_d[8*lane +: 8] = bus.i_dat;
          sel_d[lane]        = 1'b1;
          lane_d             = lane + 2'd1;
          if (lane == 2'd3 || bus.i_last) begin
            state_d = WRITE;
            last_d  = bus.i_last;
            cyc_d   = 1'b1;
            rdy_d   = 1'b0;
          end
        end
      end
      WRITE: begin
        // cyc drops on the ack edge so a registered responder never double-acks
        if (bus.i_wb_ack) begin
          cyc_d  = 1'b0;
          dat_d  = '0;
          sel_d  = '0;
          lane_d = '0;
          wadr_d = wadr + (aw-2)'(1);
          if (&wadr) wrap_d = 1'b1;
          if (last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = COLLECT;
            rdy_d   = 1'b1;
          end
        end
      end
      DONE: begin
        rdy_d = 1'b0;
        cyc_d = 1'b0;
      end
      default: state_d = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_servant_ram_loader.sv
// Randomised bench for servant_ram_loader against a queue-based write model
// and a small RAM responder with programmable ack latency.
module tb_servant_ram_loader;
  localparam int DEPTH = 16;
  localparam int W     = DEPTH / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done, wrap;

  servant_ram_loader_if bus ();

  servant_ram_loader #(.depth(DEPTH)) dut (
    .i_wb_clk  (clk),
    .i_wb_rst_n(rst_n),
    .bus       (bus),
    .o_done    (done),
    .o_wrap    (wrap)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // RAM responder: ack after a random wait, optional stray acks while idle
  logic [31:0] ram [W];
  int  wait_lo = 0, wait_hi = 0, wcnt = 0;
  bit  spur = 1'b0;
  bit  ram_clr = 1'b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.i_wb_ack <= 1'b0;
      if (ram_clr) for (int i = 0; i < W; i++) ram[i] <= '0;
    end else if (bus.o_wb_cyc && bus.i_wb_ack) begin
      for (int i = 0; i < 4; i++)
        if (bus.o_wb_sel[i]) ram[bus.o_wb_adr[1:0]][8*i +: 8] <= bus.o_wb_dat[8*i +: 8];
      bus.i_wb_ack <= 1'b0;
    end else if (bus.o_wb_cyc) begin
      if (wcnt == 0) bus.i_wb_ack <= 1'b1;
      else begin
        wcnt         <= wcnt - 1;
        bus.i_wb_ack <= 1'b0;
      end
    end else begin
      bus.i_wb_ack <= spur && ($urandom_range(3, 0) == 0);
      wcnt         <= wait_lo + int'($urandom_range(wait_hi - wait_lo, 0));
    end
  end

  // Reference model: pending-write queue plus partial-word accumulator
  typedef struct {
    int          adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          last;
  } wr_t;

  wr_t         q[$];
  logic [31:0] acc = '0;
  logic [3:0]  accsel = '0;
  int          nb = 0, wadr_m = 0;
  bit          done_m = 1'b0, wrap_m = 1'b0, live = 1'b0, started = 1'b0;
  logic [31:0] mem_m [W];

  function automatic bit rdy_m();
    return live && q.size() == 0 && !done_m;
  endfunction

  always @(posedge clk) begin : mdl
    wr_t e;
    if (!rst_n) begin
      q.delete();
      acc = '0; accsel = '0; nb = 0; wadr_m = 0;
      done_m = 1'b0; wrap_m = 1'b0; live = 1'b0;
      if (ram_clr) for (int i = 0; i < W; i++) mem_m[i] = '0;
    end else begin
      if (bus.i_wb_ack && q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 4; i++)
          if (e.sel[i]) mem_m[e.adr][8*i +: 8] = e.dat[8*i +: 8];
        if (e.adr == W - 1) wrap_m = 1'b1;
        if (e.last) done_m = 1'b1;
      end else if (bus.i_vld && rdy_m()) begin
        acc[8*nb +: 8] = bus.i_dat;
        accsel[nb]     = 1'b1;
        nb++;
        if (nb == 4 || bus.i_last) begin
          q.push_back('{wadr_m, acc, accsel, bus.i_last});
          wadr_m = (wadr_m + 1) % W;
          acc = '0; accsel = '0; nb = 0;
        end
      end
      live = 1'b1;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin : cmp
    bit          pend;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    if (started) begin
      pend = q.size() > 0;
      if (pend) begin
        ea = 32'(q[0].adr); ed = q[0].dat; es = q[0].sel;
      end else begin
        ea = 32'(wadr_m); ed = acc; es = accsel;
      end
      chk("rdy",  32'(bus.o_rdy),    32'(rdy_m()));
      chk("cyc",  32'(bus.o_wb_cyc), 32'(pend));
      chk("we",   32'(bus.o_wb_we),  32'(pend));
      chk("adr",  32'(bus.o_wb_adr), ea);
      chk("dat",  bus.o_wb_dat,      ed);
      chk("sel",  32'(bus.o_wb_sel), 32'(es));
      chk("done", 32'(done),         32'(done_m));
      chk("wrap", 32'(wrap),         32'(wrap_m));
    end
  end

  // Stimulus helpers; all called at a negedge and return at a negedge
  logic [7:0]  arr [32];
  logic [31:0] snap [W];

  task automatic idle_in();
    bus.i_vld  = 1'b0;
    bus.i_last = 1'b0;
    bus.i_dat  = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit lst, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    bus.i_dat = b; bus.i_vld = 1'b1; bus.i_last = lst;
    while (!bus.o_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("accept");
    @(negedge clk);
    idle_in();
  endtask

  task automatic send_arr(input int from, input int to, input bit lst, input int gmax);
    for (int i = from; i < to; i++)
      send_byte(arr[i], lst && (i == to - 1), int'($urandom_range(gmax, 0)));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.o_wb_cyc && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("write_ack");
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.i_vld = 1'b1; bus.i_dat = 8'hEE; bus.i_last = 1'b1;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    idle_in();
    @(negedge clk);
  endtask

  task automatic chk_ram();
    for (int i = 0; i < W; i++) chk("ram_model", ram[i], mem_m[i]);
  endtask

  function automatic logic [31:0] word_at(input int i);
    return {arr[i+3], arr[i+2], arr[i+1], arr[i]};
  endfunction

  initial begin
    int   len;
    logic [31:0] prev0;
    bus.i_vld = 1'b1; bus.i_dat = 8'h5A; bus.i_last = 1'b0;

    // reset held 3 cycles with a valid byte offered
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("rst_rdy", 32'(bus.o_rdy), 0);
      chk("rst_cyc", 32'(bus.o_wb_cyc), 0);
      chk("rst_dat", bus.o_wb_dat, 0);
      chk("rst_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    idle_in();
    @(negedge clk);
    chk("rel_rdy", 32'(bus.o_rdy), 1);
    chk("rel_sel", 32'(bus.o_wb_sel), 0);
    ram_clr = 1'b0;

    // two full words with a one-cycle responder, including ready timing
    for (int i = 0; i < 4; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0, 0);
    chk("e0_rdy", 32'(bus.o_rdy), 0);
    chk("e0_cyc", 32'(bus.o_wb_cyc), 1);
    @(negedge clk);
    chk("e1_rdy", 32'(bus.o_rdy), 0);
    @(negedge clk);
    chk("e2_rdy", 32'(bus.o_rdy), 1);
    chk("e2_cyc", 32'(bus.o_wb_cyc), 0);
    for (int i = 4; i < 8; i++) send_byte(8'(8'h11 * (i + 1)), i == 7, 0);
    wait_idle();
    chk("full_done", 32'(done), 1);
    chk("full_wrap", 32'(wrap), 0);
    chk("full_w0", ram[0], 32'h44332211);
    chk("full_w1", ram[1], 32'h88776655);
    bus.i_vld = 1'b1; bus.i_dat = 8'h99;
    repeat (4) begin
      @(negedge clk);
      chk("done_rdy", 32'(bus.o_rdy), 0);
    end
    idle_in();
    chk("done_w2", ram[2], 0);

    // partial final word keeps the untouched RAM bytes
    do_reset(2);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), i == 4, 0);
    wait_idle();
    chk("part_w0", ram[0], 32'hA3A2A1A0);
    chk("part_w1", ram[1], 32'h887766A4);
    chk("part_done", 32'(done), 1);
    chk_ram();

    // address wrap after the last word of the RAM
    do_reset(1);
    for (int i = 0; i < 20; i++) arr[i] = 8'($urandom);
    send_arr(0, 12, 1'b0, 1);
    wait_idle();
    chk("wrap_pre", 32'(wrap), 0);
    send_arr(12, 16, 1'b0, 1);
    wait_idle();
    chk("wrap_set", 32'(wrap), 1);
    send_arr(16, 20, 1'b1, 1);
    wait_idle();
    chk("wrap_w0", ram[0], word_at(16));
    chk("wrap_w1", ram[1], word_at(4));
    chk("wrap_done", 32'(done), 1);

    // same data unthrottled, then throttled with stray acks
    for (int i = 0; i < 16; i++) arr[i] = 8'($urandom);
    ram_clr = 1'b1;
    do_reset(1);
    ram_clr = 1'b0;
    send_arr(0, 16, 1'b1, 0);
    wait_idle();
    for (int i = 0; i < W; i++) begin
      snap[i] = ram[i];
      chk("unthr_w", ram[i], word_at(4 * i));
    end
    ram_clr = 1'b1;
    do_reset(1);
    ram_clr = 1'b0;
    wait_lo = 0; wait_hi = 5; spur = 1'b1;
    send_arr(0, 16, 1'b1, 3);
    wait_idle();
    for (int i = 0; i < W; i++) chk("thr_w", ram[i], snap[i]);

    // random loads of random length
    repeat (6) begin
      do_reset(1);
      wait_lo = int'($urandom_range(2, 0));
      wait_hi = wait_lo + int'($urandom_range(3, 0));
      len = int'($urandom_range(24, 1));
      for (int i = 0; i < len; i++) arr[i] = 8'($urandom);
      send_arr(0, len, 1'b1, 2);
      wait_idle();
      chk("rnd_done", 32'(done), 1);
      chk_ram();
    end

    // reset while a write is outstanding
    do_reset(1);
    spur = 1'b0; wait_lo = 8; wait_hi = 8;
    prev0 = ram[0];
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0, 0);
    @(negedge clk);
    chk("abort_pre_cyc", 32'(bus.o_wb_cyc), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_cyc", 32'(bus.o_wb_cyc), 0);
    chk("abort_adr", 32'(bus.o_wb_adr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_w0", ram[0], prev0);
    wait_lo = 0; wait_hi = 0;
    send_byte(8'h5A, 1'b0, 0);
    send_byte(8'h6B, 1'b0, 0);
    send_byte(8'h7C, 1'b0, 0);
    chk("reload_done_pre", 32'(done), 0);
    send_byte(8'h8D, 1'b1, 0);
    wait_idle();
    chk("reload_w0", ram[0], 32'h8D7C6B5A);
    chk("reload_done", 32'(done), 1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
